// File: rtl/sw_disp_pkg.sv
// Shared types and elaboration-time helpers for the seven-segment display path.
// No logic; constants only.
package sw_disp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] BLANK_NIBBLE = 4'hF;

   // Saturates at all-ones rather than wrapping, so very large DIGITS still
   // yields a limit that no input can reach.
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         if (r > 64'd1844674407370955161) r = '1;
         else                             r = r * 64'd10;
      end
      return r;
   endfunction

   // True when an IN_W-bit input can reach 10^DIGITS.
   function automatic bit needs_ovf(input int in_w, input int digits);
      if (in_w >= 64) return 1'b1;
      return (64'd1 << in_w) > pow10(digits);
   endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
// Purely combinational, no flow control.
module bcd_add3_digit (
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);

   assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/score_bcd_serializer.sv
// Iterative binary-to-BCD converter, one double-dabble shift per cycle; o_valid IN_W+1 cycles after start.
// No backpressure: i_start is accepted only in IDLE, requests while busy are dropped.
module score_bcd_serializer
   import sw_disp_pkg::*;
#(
   parameter int IN_W   = 27,
   parameter int DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [IN_W-1:0]       i_data,
   input  logic                  i_start,
   output logic                  o_busy,
   output logic                  o_valid,
   output logic [4*DIGITS-1:0]   o_seven,
   output logic                  o_overflow
);

   localparam int                BCD_W    = 4 * DIGITS;
   localparam int                CNT_W    = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(IN_W - 1);
   localparam bit                HAS_OVF  = needs_ovf(IN_W, DIGITS);

   if (IN_W < 1 || DIGITS < 1) begin : g_bad_params
      $error("score_bcd_serializer: IN_W and DIGITS must both be at least 1");
   end

   state_t               state;
   state_t               state_nxt;
   logic [IN_W-1:0]      shift_reg;
   logic [BCD_W-1:0]     scratch;
   logic [BCD_W-1:0]     scratch_adj;
   logic [CNT_W-1:0]     cnt;
   logic                 ovf_pending;
   logic                 start_ovf;
   logic                 unused_top_carry;

   // Out-of-range detection; absent when the input width cannot reach 10^DIGITS.
   if (HAS_OVF) begin : g_ovf
      localparam logic [IN_W:0] LIMIT = (IN_W + 1)'(pow10(DIGITS));
      assign start_ovf = ({1'b0, i_data} >= LIMIT);
   end else begin : g_no_ovf
      assign start_ovf = 1'b0;
   end

   for (genvar d = 0; d < DIGITS; d++) begin : g_digit
      bcd_add3_digit u_add3 (
         .digit    (scratch[4*d +: 4]),
         .adjusted (scratch_adj[4*d +: 4])
      );
   end

   // The bit leaving the top digit only matters for inputs already flagged by ovf_pending.
   assign unused_top_carry = scratch_adj[BCD_W-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_start)       state_nxt = SHIFT;
         SHIFT:   if (cnt == '0)     state_nxt = DONE;
         DONE:                       state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg   <= '0;
         scratch     <= '0;
         cnt         <= '0;
         ovf_pending <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  shift_reg   <= i_data;
                  scratch     <= '0;
                  cnt         <= CNT_LAST;
                  ovf_pending <= start_ovf;
               end
            end
            SHIFT: begin
               scratch   <= {scratch_adj[BCD_W-2:0], shift_reg[IN_W-1]};
               shift_reg <= shift_reg << 1;
               cnt       <= cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid    <= 1'b0;
         o_seven    <= '0;
         o_overflow <= 1'b0;
      end else begin
         o_valid <= (state == DONE);
         if (state == DONE) begin
            o_seven    <= ovf_pending ? {DIGITS{BLANK_NIBBLE}} : scratch;
            o_overflow <= ovf_pending;
         end
      end
   end

   assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_score_bcd_serializer.sv
// Directed bench for score_bcd_serializer: a scoreboard queue holds expected results
// and their arrival cycle; a negedge monitor pops and compares on every o_valid.
module tb_score_bcd_serializer;

   localparam int IN_W   = 27;
   localparam int DIGITS = 8;
   localparam int LAT    = IN_W + 1;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [IN_W-1:0]     i_data = '0;
   logic                i_start = 1'b0;
   logic                o_busy;
   logic                o_valid;
   logic [4*DIGITS-1:0] o_seven;
   logic                o_overflow;

   score_bcd_serializer #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_data     (i_data),
      .i_start    (i_start),
      .o_busy     (o_busy),
      .o_valid    (o_valid),
      .o_seven    (o_seven),
      .o_overflow (o_overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          at;
      logic [31:0] seven;
      logic        ovf;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_valid  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // Reference model: decimal digit extraction by division.
   function automatic logic [31:0] to_bcd(input longint unsigned v);
      logic [31:0] r;
      r = '0;
      if (v >= 64'd100000000) return 32'hFFFFFFFF;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic push_exp(input logic [IN_W-1:0] d, input int at);
      exp_t e;
      e.at    = at;
      e.seven = to_bcd(longint'(d));
      e.ovf   = (longint'(d) >= 64'd100000000);
      q.push_back(e);
   endtask

   // Start raised at negedge cyc=c is taken on edge c+1; o_valid is seen at negedge c+1+LAT.
   task automatic start_conv(input logic [IN_W-1:0] d, input bit expect_result);
      @(negedge clk);
      i_data  = d;
      i_start = 1'b1;
      if (expect_result) push_exp(d, cyc + 1 + LAT);
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic wait_drain(input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         #1;
         if (q.size() == 0) break;
      end
      chk("drain_pending", 64'(q.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (o_valid) begin
         exp_t e;
         n_valid++;
         chk("valid_expected", 64'(q.size() > 0), 64'd1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("valid_cycle", 64'(cyc), 64'(e.at));
            chk("o_seven", 64'(o_seven), 64'(e.seven));
            chk("o_overflow", 64'(o_overflow), 64'(e.ovf));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
      $fatal(1);
   end

   initial begin
      logic [IN_W-1:0] vals [8];
      int nv;
      int c;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(o_busy), 64'd0);
      chk("reset_valid", 64'(o_valid), 64'd0);
      chk("reset_seven", 64'(o_seven), 64'd0);
      chk("reset_overflow", 64'(o_overflow), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Zero input with busy profile over the conversion
      start_conv('0, 1'b1);
      for (int j = 1; j <= LAT; j++) begin
         @(negedge clk);
         chk($sformatf("busy_cycle_%0d", j), 64'(o_busy), 64'(j < LAT));
      end
      wait_drain(10);

      // Value sweep including range boundaries
      vals[0] = 27'd12345678;
      vals[1] = 27'd262143;
      vals[2] = 27'd99999999;
      vals[3] = 27'd100000000;
      vals[4] = 27'h7FFFFFF;
      vals[5] = 27'($urandom_range(99999999, 0));
      vals[6] = 27'($urandom_range(99999, 0));
      vals[7] = 27'($urandom_range(134217727, 100000000));
      foreach (vals[i]) begin
         start_conv(vals[i], 1'b1);
         wait_drain(LAT + 10);
      end

      // Second request mid-conversion is dropped
      nv = n_valid;
      start_conv(27'd5, 1'b1);
      repeat (9) @(negedge clk);
      i_data  = 27'd9;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      wait_drain(LAT + 10);
      repeat (40) @(negedge clk);
      chk("ignored_start_valids", 64'(n_valid - nv), 64'd1);

      // Level-held start refreshes every IN_W+2 cycles
      nv = n_valid;
      @(negedge clk);
      i_data  = 27'd42;
      i_start = 1'b1;
      c = cyc;
      push_exp(27'd42, c + 1 + LAT);
      push_exp(27'd42, c + 1 + LAT + (IN_W + 2));
      push_exp(27'd42, c + 1 + LAT + 2 * (IN_W + 2));
      wait_drain(4 * (IN_W + 2));
      i_start = 1'b0;
      repeat (40) @(negedge clk);
      chk("held_start_valids", 64'(n_valid - nv), 64'd3);
      chk("held_start_seven", 64'(o_seven), 64'h42);

      // Reset mid-conversion aborts without a result
      start_conv(27'd777, 1'b0);
      repeat (12) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(o_busy), 64'd0);
      chk("abort_valid", 64'(o_valid), 64'd0);
      chk("abort_seven", 64'(o_seven), 64'd0);
      chk("abort_overflow", 64'(o_overflow), 64'd0);
      nv = n_valid;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (55) @(negedge clk);
      chk("abort_no_valid", 64'(n_valid - nv), 64'd0);
      chk("abort_idle_busy", 64'(o_busy), 64'd0);
      start_conv(27'd777, 1'b1);
      wait_drain(LAT + 10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
